// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART frame blocks.
// UART_TX_BREAK_EN adds the BREAK/MARK line-break states.
package uart_pkg;

    localparam int DIV_MIN = 2;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } par_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
`ifdef UART_TX_BREAK_EN
        ,
        BREAK,
        MARK
`endif
    } tx_state_t;

    // Codes 1 and 2 carry a parity bit; 0 and 3 mean no parity.
    function automatic logic par_enabled(input logic [1:0] p);
        return (p == PAR_ODD) || (p == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: loadable bit-period counter, ticks on count == div-1.
// Shared by the TX and RX frame engines.
module uart_baud_tick #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         restart,
    input  logic [W-1:0] div,
    output logic         tick
);

    logic [W-1:0] cnt;

    assign tick = (cnt == div - W'(1));

    // Count 0..div-1; restart forces 0 so every state begins a full period.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: FIFO-fed UART transmitter, runtime word format and baud.
// UART_TX_BREAK_EN adds brk_req and the BREAK/MARK line-break states.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CLK_HZ    = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int DIV_W     = 16,
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_read,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [1:0]        cfg_parity,
    input  logic              cfg_stop2,
`ifdef UART_TX_BREAK_EN
    input  logic              brk_req,
`endif
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W       = $clog2(DATA_W + 1);
    localparam int DIV_DEFAULT = CLK_HZ / BAUD;

    tx_state_t         state_q;
    tx_state_t         state_d;
    logic [DATA_W-1:0] data_q;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_clamped;
    logic              par_en_q;
    logic              par_bit_q;
    logic              stop2_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic              tick;
    logic              restart;
    logic              last_data;
    logic              last_stop;

    assign div_clamped = (cfg_div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : cfg_div;
    assign restart     = (state_d != state_q);
    assign last_data   = (bit_cnt_q == CNT_W'(DATA_W - 1));
    assign last_stop   = (bit_cnt_q == CNT_W'(stop2_q));

    uart_baud_tick #(
        .W(DIV_W)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .div    (div_q),
        .tick   (tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame configuration is frozen in LOAD for the whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= DIV_W'(DIV_DEFAULT);
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
        end else if (state_q == LOAD) begin
            div_q     <= div_clamped;
            par_en_q  <= par_enabled(cfg_parity);
            par_bit_q <= (cfg_parity == PAR_ODD) ? ~^fifo_data : ^fifo_data;
            stop2_q   <= cfg_stop2;
        end
`ifdef UART_TX_BREAK_EN
        else if (state_q == IDLE && brk_req) begin
            div_q <= div_clamped;
        end
`endif
    end

    // Data shift register: loaded in LOAD, shifted at each data-bit end.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (state_q == LOAD) begin
            data_q <= fifo_data;
        end else if (state_q == DATA && tick) begin
            if (MSB_FIRST != 0) begin
                data_q <= data_q << 1;
            end else begin
                data_q <= data_q >> 1;
            end
        end
    end

    // Bit counter: data bits in DATA, stop bits in STOP; zeroed on entry.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            bit_cnt_q <= '0;
        end else if (tick) begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        end
    end

    // Next-state and line outputs.
    always_comb begin
        state_d    = state_q;
        fifo_read  = 1'b0;
        tx         = 1'b1;
        busy       = 1'b1;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (!fifo_empty && !rst) begin
                    fifo_read = 1'b1;
                    state_d   = LOAD;
                end
`ifdef UART_TX_BREAK_EN
                if (brk_req) begin
                    fifo_read = 1'b0;
                    state_d   = BREAK;
                end
`endif
            end
            LOAD: begin
                state_d = START;
            end
            START: begin
                tx = 1'b0;
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                tx = (MSB_FIRST != 0) ? data_q[DATA_W-1] : data_q[0];
                if (tick && last_data) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                tx = par_bit_q;
                if (tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick && last_stop) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
            end
`ifdef UART_TX_BREAK_EN
            BREAK: begin
                tx = 1'b0;
                if (!brk_req) begin
                    state_d = MARK;
                end
            end
            MARK: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
